// File: rtl/ws281x_sched_pkg.sv
// Shared types and default sizing for the WS281x pixel scheduler.
// Build option: WS281X_PIX_SCHED_GRB_EN selects {G,R,B} output ordering.
package ws281x_sched_pkg;

    localparam int NP_DEF = 2;
    localparam int AW_DEF = 8;
    localparam int LW_DEF = 8;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_FETCH = 2'd1,
        ST_PUSH  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ws281x_rr_arb.sv
// Combinational round-robin arbiter: the search starts at the port after ptr
// and wraps, so the port at ptr itself has the lowest priority.
import ws281x_sched_pkg::*;

module ws281x_rr_arb #(
    parameter int NP = NP_DEF,
    parameter int PW = (NP > 1) ? $clog2(NP) : 1
) (
    input  logic [NP-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NP-1:0] grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NP; k++) begin
            idx = PW'((int'(ptr) + k) % NP);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ws281x_pix_sched.sv
// Pixel-RAM read scheduler feeding NP WS281x driver FIFOs, one pixel per grant.
// Build option: WS281X_PIX_SCHED_GRB_EN reorders pixel words to {G,R,B}.
import ws281x_sched_pkg::*;

module ws281x_pix_sched #(
    parameter int NP = NP_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic             mclk,
    input  logic             h_reset_n,
    input  logic [NP-1:0]    start,
    input  logic             abort,
    input  logic [NP*AW-1:0] base_addr,
    input  logic [NP*LW-1:0] pix_cnt,
    input  logic [NP-1:0]    fifo_full,
    output logic             mem_req,
    output logic [AW-1:0]    mem_addr,
    input  logic             mem_ack,
    input  logic [23:0]      mem_rdata,
    output logic [NP-1:0]    fifo_wr,
    output logic [23:0]      fifo_wdata,
    output logic [NP-1:0]    busy,
    output logic [NP-1:0]    done,
    output logic [1:0]       state_dbg
);

    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    // Memory handshake: mem_req rises with mem_addr valid and both stay
    // constant until the first cycle mem_ack is seen high; mem_rdata is taken
    // in that cycle and mem_req drops on the next edge.

    sched_state_t  state;
    logic [NP-1:0] busy_q;
    logic [NP-1:0] done_q;
    logic [NP-1:0] fifo_wr_q;
    logic          mem_req_q;
    logic [AW-1:0] mem_addr_q;
    logic [23:0]   fifo_wdata_q;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic [AW-1:0] addr_q [NP];
    logic [LW-1:0] rem_q  [NP];

    logic [NP-1:0] arb_req;
    logic [NP-1:0] grant;
    logic [PW-1:0] grant_enc;

    function automatic logic [23:0] pix_order(input logic [23:0] rgb);
`ifdef WS281X_PIX_SCHED_GRB_EN
        pix_order = {rgb[15:8], rgb[23:16], rgb[7:0]};
`else
        pix_order = rgb;
`endif
    endfunction

    // A full FIFO only blocks new grants; a fetch already in flight completes.
    assign arb_req = busy_q & ~fifo_full;

    ws281x_rr_arb #(
        .NP (NP),
        .PW (PW)
    ) u_rr_arb (
        .req   (arb_req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        grant_enc = '0;
        for (int p = 0; p < NP; p++) begin
            if (grant[p]) grant_enc = PW'(p);
        end
    end

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            state        <= ST_ARB;
            busy_q       <= '0;
            done_q       <= '0;
            fifo_wr_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            fifo_wdata_q <= '0;
            rr_ptr       <= PW'(NP - 1);
            grant_idx    <= '0;
            for (int p = 0; p < NP; p++) begin
                addr_q[p] <= '0;
                rem_q[p]  <= '0;
            end
        end else begin
            done_q    <= '0;
            fifo_wr_q <= '0;
            if (abort) begin
                busy_q    <= '0;
                mem_req_q <= 1'b0;
                state     <= ST_ARB;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (start[p] && !busy_q[p]) begin
                        if (pix_cnt[p*LW +: LW] != '0) begin
                            busy_q[p] <= 1'b1;
                            addr_q[p] <= base_addr[p*AW +: AW];
                            rem_q[p]  <= pix_cnt[p*LW +: LW];
                        end else begin
                            done_q[p] <= 1'b1;
                        end
                    end
                end

                case (state)
                    ST_ARB: begin
                        if (|grant) begin
                            grant_idx  <= grant_enc;
                            rr_ptr     <= grant_enc;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= addr_q[grant_enc];
                            state      <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (mem_ack) begin
                            mem_req_q            <= 1'b0;
                            fifo_wdata_q         <= pix_order(mem_rdata);
                            fifo_wr_q[grant_idx] <= 1'b1;
                            state                <= ST_PUSH;
                        end
                    end
                    ST_PUSH: begin
                        addr_q[grant_idx] <= addr_q[grant_idx] + 1'b1;
                        rem_q[grant_idx]  <= rem_q[grant_idx] - 1'b1;
                        if (rem_q[grant_idx] == LW'(1)) begin
                            busy_q[grant_idx] <= 1'b0;
                            done_q[grant_idx] <= 1'b1;
                        end
                        state <= ST_ARB;
                    end
                    default: state <= ST_ARB;
                endcase
            end
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign fifo_wr    = fifo_wr_q;
    assign fifo_wdata = fifo_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_dbg  = state;

endmodule

// File: doc/ws281x_pix_sched.md
WS281X_PIX_SCHED -- requirements
Module: ws281x_pix_sched

Interface
REQ-001 SHALL have parameter NP, default 2, number of LED ports served.
REQ-002 SHALL have parameter AW, default 8, pixel-RAM word address width.
REQ-003 SHALL have parameter LW, default 8, per-port pixel-count width.
REQ-004 SHALL have port mclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port h_reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  NP  per-port one-cycle frame-start pulse.
REQ-007 SHALL have port abort  input  1  one-cycle pulse cancelling all frames.
REQ-008 SHALL have port base_addr  input  NP*AW  per-port first RAM word, port p at [p*AW +: AW].
REQ-009 SHALL have port pix_cnt  input  NP*LW  per-port pixel count, port p at [p*LW +: LW].
REQ-010 SHALL have port fifo_full  input  NP  per-port driver FIFO full flag.
REQ-011 SHALL have port mem_req  output  1  pixel-RAM read request.
REQ-012 SHALL have port mem_addr  output  AW  pixel-RAM read address.
REQ-013 SHALL have port mem_ack  input  1  read complete; mem_rdata valid this cycle.
REQ-014 SHALL have port mem_rdata  input  24  pixel word {R,G,B}.
REQ-015 SHALL have port fifo_wr  output  NP  one-hot driver FIFO write strobe.
REQ-016 SHALL have port fifo_wdata  output  24  pixel word to driver FIFO.
REQ-017 SHALL have port busy  output  NP  port frame in progress.
REQ-018 SHALL have port done  output  NP  one-cycle frame-complete pulse.

Function
REQ-019 SHALL sample base_addr/pix_cnt into per-port addr/remaining counters on start when port not busy; start on busy port ignored.
REQ-020 SHALL set busy[p] the cycle after accepted start with pix_cnt!=0; pix_cnt==0 yields done[p] pulse the cycle after start, busy stays 0.
REQ-021 SHALL run FSM ARB -> FETCH -> PUSH -> ARB; reset state ARB.
REQ-022 ARB: grant next busy port with !fifo_full, round-robin starting after last granted port; no candidate -> stay ARB.
REQ-023 FETCH: mem_req=1, mem_addr=granted port addr, held stable until mem_ack; on mem_ack capture mem_rdata, go PUSH.
REQ-024 PUSH: fifo_wr[grant]=1 for exactly one cycle with captured word; addr increments modulo 2^AW (wraps 2^AW-1 -> 0); remaining decrements.
REQ-025 SHALL, when remaining reaches 0 in PUSH, clear busy[p] and pulse done[p] on next cycle.
REQ-026 Throughput with zero-wait mem_ack: one pixel per 3 cycles; first mem_req asserted second cycle after start pulse.
REQ-027 abort SHALL clear all busy, drop mem_req next cycle, return FSM to ARB, suppress done and any pending fifo_wr; abort wins over simultaneous start.
REQ-028 Simultaneous start on several ports SHALL all be accepted.
REQ-029 mem_req, fifo_wr SHALL never both be high in the same cycle.

Reset
REQ-030 On h_reset_n low: state ARB, busy=0, done=0, fifo_wr=0, mem_req=0, mem_addr=0, fifo_wdata=0, round-robin pointer at port NP-1 (port 0 first).
REQ-031 Reset mid-FETCH SHALL deassert mem_req asynchronously; no residual write after release.

Configuration
REQ-032 Macro WS281X_PIX_SCHED_GRB_EN defined: fifo_wdata = {G,R,B} reorder of captured {R,G,B}.
REQ-033 Macro undefined: fifo_wdata = captured word unchanged.

Structure
REQ-034 Package ws281x_sched_pkg SHALL hold FSM state enum and default NP/AW/LW constants.
REQ-035 Round-robin grant SHALL be sub-module ws281x_rr_arb (request NP, pointer in, one-hot grant out, combinational).

Verification
REQ-036 start[0], base=0x10, cnt=3, mem_ack zero-wait -> reads 0x10,0x11,0x12; three fifo_wr[0]; done[0] one pulse; busy[0] low after.
REQ-037 Both ports start same cycle, cnt=2 each -> fifo_wr order port0,port1,port0,port1.
REQ-038 fifo_full[1]=1 with both busy -> only port0 served; release fifo_full[1] -> port1 resumes at its saved addr.
REQ-039 base=0xFF, cnt=2 -> mem_addr 0xFF then 0x00.
REQ-040 abort during FETCH with mem_ack stalled -> mem_req low next cycle, no fifo_wr, no done, busy=0.
REQ-041 mem_rdata=0x112233, GRB_EN defined -> fifo_wdata=0x221133; undefined -> 0x112233.
